fifo_rd_packer: RTL and testbench

Read-side consumer of the async FIFO, in the rclk domain. Pops DATASIZE-wide words through the FIFO's show-ahead read port (rempty/rinc/rdata) and packs PACK consecutive words into one wide beat. Presents each beat on a valid/ready stream. Partial beats are emitted, with lane-valid flags, on an explicit flush or after an idle timeout.

---
 rtl/fifo_rd_packer.sv | 112 +++++++++++
 tb/tb_fifo_rd_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops show-ahead words and packs PACK of
// them into one wide valid/ready beat, with lane-valid flags for partial beats.
module fifo_rd_packer #(
   parameter int DATASIZE = 8,
   parameter int PACK     = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic                     rempty,
   input  logic [DATASIZE-1:0]      rdata,
   output logic                     rinc,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATASIZE*PACK-1:0] m_data,
   output logic [PACK-1:0]          m_keep
);

   localparam int CW = $clog2(PACK + 1);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
   localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [PACK-1:0][DATASIZE-1:0] acc_q, acc_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          flush_pend_q, flush_pend_d;
   logic [TW-1:0]                 timer_q, timer_d;
   logic                          m_valid_q, m_valid_d;
   logic [DATASIZE*PACK-1:0]      m_data_q, m_data_d;
   logic [PACK-1:0]               m_keep_q, m_keep_d;

   logic            st_ready, st_fill, out_free, xfer, pop, tmo_fire;
   logic [PACK-1:0] lane_mask;

   always_comb begin
      st_ready = (cnt_q == CNT_FULL) || (flush_pend_q && (cnt_q != '0));
      st_fill  = (cnt_q != '0) && (cnt_q != CNT_FULL) && !flush_pend_q;
      out_free = !m_valid_q || m_ready;
      xfer     = st_ready && out_free;
      // Popping is allowed in the handoff cycle: the new word becomes lane 0.
      pop      = rrst_n && !rempty && (xfer || ((cnt_q != CNT_FULL) && !flush_pend_q));
      tmo_fire = (TIMEOUT > 0) && st_fill && !pop && (timer_q == T_LAST);
      for (int i = 0; i < PACK; i++) begin
         lane_mask[i] = (CW'(i) < cnt_q);
      end
   end

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      timer_d   = timer_q;

      if (xfer) begin
         m_valid_d = 1'b1;
         m_keep_d  = lane_mask;
         for (int i = 0; i < PACK; i++) begin
            m_data_d[i*DATASIZE +: DATASIZE] = lane_mask[i] ? acc_q[i] : '0;
         end
         cnt_d = '0;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      if (pop) begin
         for (int i = 0; i < PACK; i++) begin
            if (cnt_d == CW'(i)) begin
               acc_d[i] = rdata;
            end
         end
         cnt_d = cnt_d + CW'(1);
      end

      // A flush only sticks when something will actually be in the accumulator.
      flush_pend_d = ((flush || tmo_fire) && (cnt_d != '0)) || (flush_pend_q && !xfer);

      if (pop || xfer || !st_fill || (TIMEOUT == 0)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         timer_q      <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         timer_q      <= timer_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
      end
   end

   assign rinc    = pop;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the show-ahead FIFO and
// every accepted beat is logged as {m_keep, m_data} for comparison.
module tb_fifo_rd_packer;

   localparam int DS = 8;
   localparam int PK = 4;
   localparam int TO = 16;

   logic             rclk    = 1'b0;
   logic             rrst_n  = 1'b0;
   logic             rempty  = 1'b1;
   logic [DS-1:0]    rdata   = '0;
   logic             flush   = 1'b0;
   logic             m_ready = 1'b0;
   logic             rinc;
   logic             m_valid;
   logic [DS*PK-1:0] m_data;
   logic [PK-1:0]    m_keep;

   logic [DS-1:0]    fifo_q[$];
   logic [35:0]      got[$];
   int               checks  = 0;
   int               errors  = 0;
   int               pop_cnt = 0;
   int               vcnt;

   fifo_rd_packer #(.DATASIZE(DS), .PACK(PK), .TIMEOUT(TO)) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rempty  (rempty),
      .rdata   (rdata),
      .rinc    (rinc),
      .flush   (flush),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_keep  (m_keep)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      rempty = (fifo_q.size() == 0);
      rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push(input logic [DS-1:0] w);
      fifo_q.push_back(w);
      refresh();
   endtask

   // One rclk cycle: sample at the falling edge, apply the pop 1ns after the rising edge.
   task automatic cyc();
      logic pop_s;
      @(negedge rclk);
      pop_s = rinc;
      if (m_valid && m_ready && rrst_n) got.push_back({m_keep, m_data});
      @(posedge rclk);
      #1;
      if (pop_s && fifo_q.size() != 0) begin
         void'(fifo_q.pop_front());
         pop_cnt++;
      end
      refresh();
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [35:0] exp);
      check(tag, (got.size() > idx) ? got[idx] : 36'h0, exp);
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_keep", m_keep, 0);
      check("rst_rinc", rinc, 0);
      cycn(2);
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      cycn(2);

      // 1: full-rate streaming
      got.delete();
      pop_cnt = 0;
      for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
      cycn(8);
      check("t1_pops", pop_cnt, 8);
      cycn(4);
      check("t1_nbeats", got.size(), 2);
      chk_beat("t1_b0", 0, 36'hF_44332211);
      chk_beat("t1_b1", 1, 36'hF_88776655);

      // 2: backpressure
      got.delete();
      pop_cnt = 0;
      m_ready = 1'b0;
      for (int i = 1; i <= 12; i++) push(8'(i));
      cycn(9);
      check("t2_valid", m_valid, 1);
      check("t2_data_a", m_data, 32'h04030201);
      check("t2_keep", m_keep, 4'hF);
      cycn(3);
      check("t2_pops", pop_cnt, 8);
      check("t2_left", fifo_q.size(), 4);
      check("t2_rinc", rinc, 0);
      check("t2_rempty", rempty, 0);
      check("t2_data_b", m_data, 32'h04030201);
      m_ready = 1'b1;
      cycn(8);
      check("t2_nbeats", got.size(), 3);
      chk_beat("t2_b0", 0, 36'hF_04030201);
      chk_beat("t2_b1", 1, 36'hF_08070605);
      chk_beat("t2_b2", 2, 36'hF_0C0B0A09);

      // 3: idle timeout, then a late word that restarts the timer
      got.delete();
      push(8'hA1); push(8'hA2); push(8'hA3);
      cycn(3);
      cycn(16);
      check("t3_early", m_valid, 0);
      cyc();
      check("t3_valid", m_valid, 1);
      check("t3_data", m_data, 32'h00A3A2A1);
      check("t3_keep", m_keep, 4'h7);
      cycn(3);
      push(8'hA1); push(8'hA2); push(8'hA3);
      cycn(3);
      cycn(10);
      push(8'hA4);
      cyc();
      check("t3_nofire", m_valid, 0);
      cyc();
      check("t3_full_v", m_valid, 1);
      check("t3_full_d", m_data, 32'hA4A3A2A1);
      check("t3_full_k", m_keep, 4'hF);
      cycn(25);
      check("t3_nbeats", got.size(), 2);

      // 4: flush on an empty accumulator, then a single-word flush
      got.delete();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cycn(5);
      check("t4_ignored", got.size(), 0);
      push(8'h5A);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      check("t4_valid", m_valid, 1);
      check("t4_data", m_data, 32'h0000005A);
      check("t4_keep", m_keep, 4'h1);
      cycn(3);

      // 5: flush coinciding with a pop; the next word starts a new beat
      got.delete();
      push(8'h10); push(8'h20); push(8'h30);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      check("t5_data", m_data, 32'h00002010);
      check("t5_keep", m_keep, 4'h3);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      check("t5_next_d", m_data, 32'h00000030);
      check("t5_next_k", m_keep, 4'h1);
      cycn(3);
      check("t5_nbeats", got.size(), 2);

      // 6: reset mid-operation with a held beat and a partial accumulator
      got.delete();
      m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(8'(i));
      cycn(6);
      check("t6_held", m_valid, 1);
      push(8'hEE);
      #1;
      check("t6_rinc_pre", rinc, 1);
      rrst_n = 1'b0;
      #1;
      check("t6_valid", m_valid, 0);
      check("t6_data", m_data, 0);
      check("t6_keep", m_keep, 0);
      check("t6_rinc", rinc, 0);
      fifo_q.delete();
      refresh();
      cycn(2);
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (m_valid) vcnt++;
      end
      check("t6_quiet", vcnt, 0);
      push(8'hC1);
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      check("t6_lane0_d", m_data, 32'h000000C1);
      check("t6_lane0_k", m_keep, 4'h1);
      cycn(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
